// File: rtl/load_data_unit.sv
// Sequential load path: one request at a time, one or two aligned bus reads,
// beat merge for boundary-crossing accesses, zero/sign extension of the result.
package CorePack;
  typedef enum logic [2:0] {
    MEM_B, MEM_UB, MEM_H, MEM_UH, MEM_W, MEM_UW, MEM_D, MEM_NO
  } mem_op_enum;

  typedef enum logic [2:0] {
    S_IDLE, S_REQ0, S_WAIT0, S_REQ1, S_WAIT1, S_DRAIN, S_RESP
  } ldu_state_e;
endpackage

// Handshakes: a transfer happens on a rising edge where valid and ready are both
// high; valid and its payload stay stable until that edge. mem_rvalid has no ready.
module load_data_unit
  import CorePack::*;
#(
  parameter int DATA_W           = 64,
  parameter int ADDR_W           = 64,
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  mem_op_enum        req_op,
  input  logic              flush,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_fault,
  output ldu_state_e        dbg_state
);

  localparam int BYTES = DATA_W / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam int DW2   = 2 * DATA_W;

  function automatic logic [3:0] op_size(input mem_op_enum op);
    case (op)
      MEM_B, MEM_UB: op_size = 4'd1;
      MEM_H, MEM_UH: op_size = 4'd2;
      MEM_W, MEM_UW: op_size = 4'd4;
      MEM_D:         op_size = 4'd8;
      default:       op_size = 4'd0;
    endcase
  endfunction

  function automatic logic op_signed(input mem_op_enum op);
    op_signed = (op == MEM_B) || (op == MEM_H) || (op == MEM_W) || (op == MEM_D);
  endfunction

  // MEM_NO has size 0, so it merges to all zeros without a special case.
  function automatic logic [DATA_W-1:0] merge_beats(input logic [DW2-1:0] cat,
                                                    input logic [OFF_W-1:0] off,
                                                    input mem_op_enum op);
    logic [DW2-1:0]    sh;
    logic [DATA_W-1:0] res;
    logic              top;
    int                nbits;
    sh    = cat >> {off, 3'b000};
    nbits = 8 * int'(op_size(op));
    top   = 1'b0;
    res   = '0;
    for (int i = 0; i < DATA_W; i++) begin
      if (i == nbits - 1) top = sh[i];
    end
    for (int i = 0; i < DATA_W; i++) begin
      if (i < nbits) res[i] = sh[i];
      else           res[i] = top & op_signed(op);
    end
    return res;
  endfunction

  ldu_state_e        state_q, state_d;
  mem_op_enum        op_q, op_d;
  logic [OFF_W-1:0]  off_q, off_d;
  logic              cross_q, cross_d;
  logic [DATA_W-1:0] beat0_q, beat0_d;
  logic [DATA_W-1:0] beat1_q, beat1_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              rsp_fault_q, rsp_fault_d;

  logic [OFF_W-1:0]  req_off;
  logic [4:0]        req_span;
  logic              req_cross;
  logic              req_bad;
  logic [ADDR_W-1:0] req_aligned;

  always_comb begin
    req_off     = req_addr[OFF_W-1:0];
    req_span    = 5'(req_off) + 5'(op_size(req_op));
    req_cross   = req_span > 5'(BYTES);
    req_bad     = (req_cross && !ALLOW_MISALIGNED) || (req_op == MEM_D && DATA_W == 32);
    req_aligned = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    off_d       = off_q;
    cross_d     = cross_q;
    beat0_d     = beat0_q;
    beat1_d     = beat1_q;
    mem_addr_d  = mem_addr_q;
    rsp_fault_d = rsp_fault_q;
    case (state_q)
      S_IDLE: begin
        // A flush in IDLE suppresses acceptance for that cycle.
        if (req_valid && !flush) begin
          op_d        = req_op;
          off_d       = req_off;
          cross_d     = req_cross;
          rsp_fault_d = 1'b0;
          if (req_op == MEM_NO || req_bad) begin
            beat0_d     = '0;
            beat1_d     = '0;
            rsp_fault_d = (req_op != MEM_NO);
            state_d     = S_RESP;
          end else begin
            mem_addr_d = req_aligned;
            state_d    = S_REQ0;
          end
        end
      end
      S_REQ0: begin
        if (mem_req_ready) state_d = flush ? S_DRAIN : S_WAIT0;
        else if (flush)    state_d = S_IDLE;
      end
      S_WAIT0: begin
        if (mem_rvalid) begin
          if (flush) begin
            state_d = S_IDLE;
          end else if (cross_q) begin
            beat0_d    = mem_rdata;
            mem_addr_d = mem_addr_q + ADDR_W'(BYTES);
            state_d    = S_REQ1;
          end else begin
            beat0_d = mem_rdata;
            beat1_d = '0;
            state_d = S_RESP;
          end
        end else if (flush) begin
          state_d = S_DRAIN;
        end
      end
      S_REQ1: begin
        if (mem_req_ready) state_d = flush ? S_DRAIN : S_WAIT1;
        else if (flush)    state_d = S_IDLE;
      end
      S_WAIT1: begin
        if (mem_rvalid) begin
          if (flush) begin
            state_d = S_IDLE;
          end else begin
            beat1_d = mem_rdata;
            state_d = S_RESP;
          end
        end else if (flush) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (mem_rvalid) state_d = S_IDLE;
      end
      S_RESP: begin
        if (flush || rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      op_q        <= MEM_B;
      off_q       <= '0;
      cross_q     <= 1'b0;
      beat0_q     <= '0;
      beat1_q     <= '0;
      mem_addr_q  <= '0;
      rsp_fault_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      off_q       <= off_d;
      cross_q     <= cross_d;
      beat0_q     <= beat0_d;
      beat1_q     <= beat1_d;
      mem_addr_q  <= mem_addr_d;
      rsp_fault_q <= rsp_fault_d;
    end
  end

  assign req_ready     = (state_q == S_IDLE);
  assign mem_req_valid = (state_q == S_REQ0) || (state_q == S_REQ1);
  assign mem_req_addr  = mem_addr_q;
  assign rsp_valid     = (state_q == S_RESP);
  assign rsp_fault     = rsp_fault_q;
  assign rsp_data      = merge_beats({beat1_q, beat0_q}, off_q, op_q);
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_load_data_unit.sv
// Bench for load_data_unit: a 64-bit unit with misaligned support behind a bus
// model, plus a 32-bit unit without it for the fault paths.
module tb_load_data_unit;
  import CorePack::*;

  localparam int DW = 64;
  localparam int AW = 64;

  logic          clk = 1'b0;
  logic          rstn;
  logic          req_valid, req_ready, flush;
  logic [AW-1:0] req_addr;
  mem_op_enum    req_op;
  logic          mem_req_valid, mem_req_ready, mem_rvalid;
  logic [AW-1:0] mem_req_addr;
  logic [DW-1:0] mem_rdata;
  logic          rsp_valid, rsp_ready, rsp_fault;
  logic [DW-1:0] rsp_data;
  ldu_state_e    dbg_state;

  logic          nm_req_valid, nm_req_ready, nm_mem_req_valid, nm_rsp_valid, nm_rsp_fault;
  logic [31:0]   nm_req_addr, nm_mem_req_addr, nm_rsp_data;
  mem_op_enum    nm_req_op;
  ldu_state_e    nm_dbg_state;

  always #5 clk = ~clk;

  load_data_unit #(.DATA_W(64), .ADDR_W(64), .ALLOW_MISALIGNED(1'b1)) u_dut (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_op(req_op), .flush(flush),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_fault(rsp_fault), .dbg_state(dbg_state)
  );

  load_data_unit #(.DATA_W(32), .ADDR_W(32), .ALLOW_MISALIGNED(1'b0)) u_dut_nm (
    .clk(clk), .rstn(rstn), .req_valid(nm_req_valid), .req_ready(nm_req_ready),
    .req_addr(nm_req_addr), .req_op(nm_req_op), .flush(1'b0),
    .mem_req_valid(nm_mem_req_valid), .mem_req_ready(1'b1),
    .mem_req_addr(nm_mem_req_addr), .mem_rvalid(1'b0), .mem_rdata(32'h0),
    .rsp_valid(nm_rsp_valid), .rsp_ready(1'b1), .rsp_data(nm_rsp_data),
    .rsp_fault(nm_rsp_fault), .dbg_state(nm_dbg_state)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard state: {fault, data} plus the cycle the response must first appear.
  logic [DW:0]   exp_q[$];
  int            exp_cyc_q[$];
  logic [32:0]   nm_exp_q[$];
  int            nm_exp_cyc_q[$];
  logic [AW-1:0] exp_addr_q[$];
  logic [DW-1:0] beat_q[$];
  int            stall_cnt = 0;
  int            rv_delay  = 1;
  bit            mon_first = 1'b1;
  bit            nm_req_seen = 1'b0;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] need);
    total++;
    if (act !== need) begin
      bad++;
      $display("FAIL %s: got 0x%0h, need 0x%0h", nm, act, need);
    end
  endtask

  task automatic fail(input string nm);
    total++;
    bad++;
    $display("FAIL %s", nm);
  endtask

  // Response monitor for the 64-bit unit; checks data every cycle rsp_valid is up.
  initial begin : rsp_mon
    logic [DW:0] e;
    forever begin
      @(negedge clk);
      if (rstn && rsp_valid) begin
        if (exp_q.size() == 0) begin
          fail("rsp_unexpected");
        end else begin
          e = exp_q[0];
          check("rsp_data", rsp_data, e[DW-1:0]);
          check("rsp_fault", rsp_fault, e[DW]);
          if (mon_first && exp_cyc_q[0] >= 0) check("rsp_latency", cyc, exp_cyc_q[0]);
          mon_first = 1'b0;
          if (rsp_ready) begin
            void'(exp_q.pop_front());
            void'(exp_cyc_q.pop_front());
            mon_first = 1'b1;
          end
        end
      end
    end
  end

  initial begin : nm_mon
    logic [32:0] e;
    forever begin
      @(negedge clk);
      if (rstn && nm_mem_req_valid) nm_req_seen = 1'b1;
      if (rstn && nm_rsp_valid) begin
        if (nm_exp_q.size() == 0) begin
          fail("nm_rsp_unexpected");
        end else begin
          e = nm_exp_q.pop_front();
          check("nm_rsp_data", nm_rsp_data, e[31:0]);
          check("nm_rsp_fault", nm_rsp_fault, e[32]);
          check("nm_rsp_latency", cyc, nm_exp_cyc_q.pop_front());
        end
      end
    end
  end

  // Bus model: ready stalls, address checks while requesting, rvalid rv_delay cycles after accept.
  initial begin : bus
    int cd;
    cd = 0;
    mem_req_ready = 1'b0;
    mem_rvalid    = 1'b0;
    mem_rdata     = '0;
    forever begin
      @(negedge clk);
      mem_rvalid = 1'b0;
      if (!rstn) begin
        cd = 0;
      end else if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          mem_rvalid = 1'b1;
          if (beat_q.size() == 0) begin
            fail("bus_no_beat");
            mem_rdata = '0;
          end else begin
            mem_rdata = beat_q.pop_front();
          end
        end
      end
      if (mem_req_valid && stall_cnt > 0) begin
        mem_req_ready = 1'b0;
        stall_cnt--;
      end else begin
        mem_req_ready = 1'b1;
      end
      if (rstn && mem_req_valid) begin
        if (exp_addr_q.size() == 0) begin
          fail("mem_req_unexpected");
        end else begin
          check("mem_req_addr", mem_req_addr, exp_addr_q[0]);
          if (mem_req_ready) begin
            void'(exp_addr_q.pop_front());
            cd = rv_delay;
          end
        end
      end
    end
  end

  task automatic do_load(input logic [AW-1:0] a, input mem_op_enum op,
                         input logic [DW-1:0] d, input logic f, input int lat,
                         input bit want);
    int n;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      fail("req_ready_timeout");
    end else begin
      req_valid = 1'b1;
      req_addr  = a;
      req_op    = op;
      if (want) begin
        exp_q.push_back({f, d});
        exp_cyc_q.push_back(lat > 0 ? cyc + lat : -1);
      end
      @(negedge clk);
      req_valid = 1'b0;
    end
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!(exp_q.size() == 0 && exp_addr_q.size() == 0 && req_ready) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) fail("drain_timeout");
  endtask

  task automatic bus_push(input logic [AW-1:0] a, input logic [DW-1:0] b);
    exp_addr_q.push_back(a);
    beat_q.push_back(b);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "simulation did not finish");
  end

  initial begin : main
    int n;
    rstn = 1'b1;
    req_valid = 1'b0; req_addr = '0; req_op = MEM_NO; flush = 1'b0; rsp_ready = 1'b1;
    nm_req_valid = 1'b0; nm_req_addr = '0; nm_req_op = MEM_NO;
    #2 rstn = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_req_ready", req_ready, 1);
    check("rst_mem_req_valid", mem_req_valid, 0);
    check("rst_mem_req_addr", mem_req_addr, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_rsp_fault", rsp_fault, 0);
    rstn = 1'b1;

    // Aligned byte/half/double loads, signed and unsigned.
    bus_push(64'h1000, 64'h1122_3344_8566_7788);
    do_load(64'h1003, MEM_B, 64'hFFFF_FFFF_FFFF_FF85, 1'b0, 3, 1'b1); wait_done();
    bus_push(64'h1000, 64'h1122_3344_8566_7788);
    do_load(64'h1003, MEM_UB, 64'h85, 1'b0, 3, 1'b1); wait_done();
    bus_push(64'h1000, 64'h0000_0000_0000_8001);
    do_load(64'h1000, MEM_UH, 64'h8001, 1'b0, 3, 1'b1); wait_done();
    bus_push(64'h1000, 64'h0000_8001_0000_0000);
    do_load(64'h1004, MEM_H, 64'hFFFF_FFFF_FFFF_8001, 1'b0, 3, 1'b1); wait_done();
    do_load(64'h1234, MEM_NO, 64'h0, 1'b0, 1, 1'b1); wait_done();
    bus_push(64'h1008, 64'h0123_4567_89AB_CDEF);
    do_load(64'h1008, MEM_D, 64'h0123_4567_89AB_CDEF, 1'b0, 3, 1'b1); wait_done();

    // Boundary-crossing loads, including a second address that wraps to zero.
    bus_push(64'h1000, 64'hAABB_CCDD_EEFF_0011); bus_push(64'h1008, 64'h2233_4455_6677_8899);
    do_load(64'h1006, MEM_UW, 64'h0000_0000_8899_AABB, 1'b0, 5, 1'b1); wait_done();
    bus_push(64'h1000, 64'hAABB_CCDD_EEFF_0011); bus_push(64'h1008, 64'h2233_4455_6677_8899);
    do_load(64'h1006, MEM_W, 64'hFFFF_FFFF_8899_AABB, 1'b0, 5, 1'b1); wait_done();
    bus_push(64'h1000, 64'h8877_6655_4433_2211); bus_push(64'h1008, 64'hFFEE_DDCC_BBAA_9900);
    do_load(64'h1004, MEM_D, 64'hBBAA_9900_8877_6655, 1'b0, 5, 1'b1); wait_done();
    bus_push(64'hFFFF_FFFF_FFFF_FFF8, 64'h1234_0000_0000_0000); bus_push(64'h0, 64'h5678);
    do_load(64'hFFFF_FFFF_FFFF_FFFE, MEM_W, 64'h5678_1234, 1'b0, 5, 1'b1); wait_done();

    // Back-to-back requests.
    bus_push(64'h1000, 64'h0000_0000_0000_AB00);
    do_load(64'h1001, MEM_UB, 64'hAB, 1'b0, 3, 1'b1);
    do_load(64'h1001, MEM_NO, 64'h0, 1'b0, 1, 1'b1);
    wait_done();

    // Bus stall of 4 cycles and consumer stall of 3 cycles.
    stall_cnt = 4;
    rsp_ready = 1'b0;
    bus_push(64'h1010, 64'h0011_2233_C455_8899);
    do_load(64'h1012, MEM_H, 64'hFFFF_FFFF_FFFF_C455, 1'b0, -1, 1'b1);
    n = 0;
    while (!rsp_valid && n < 100) begin @(negedge clk); n++; end
    if (!rsp_valid) fail("stall_rsp_timeout");
    repeat (3) @(negedge clk);
    @(posedge clk); #1 rsp_ready = 1'b1;
    wait_done();

    // Flush while the first request is stalled: no bus transfer, no response.
    stall_cnt = 3;
    exp_addr_q.push_back(64'h1100);
    do_load(64'h1100, MEM_D, 64'h0, 1'b0, -1, 1'b0);
    n = 0;
    while (!mem_req_valid && n < 20) begin @(negedge clk); n++; end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    exp_addr_q.delete();
    stall_cnt = 0;
    check("flush_req0_state", dbg_state, S_IDLE);

    // Flush in WAIT0 with the beat two cycles late; the stale beat must be discarded.
    rv_delay = 3;
    bus_push(64'h1200, 64'hDEAD_BEEF_DEAD_BEEF);
    do_load(64'h1200, MEM_D, 64'h0, 1'b0, -1, 1'b0);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    rv_delay = 1;
    check("flush_wait0_state", dbg_state, S_DRAIN);
    bus_push(64'h1208, 64'h0F1E_2D3C_4B5A_6978);
    do_load(64'h1208, MEM_D, 64'h0F1E_2D3C_4B5A_6978, 1'b0, 3, 1'b1); wait_done();

    // Unsupported accesses on the 32-bit unit without misaligned support.
    @(negedge clk);
    nm_req_valid = 1'b1; nm_req_addr = 32'h1007; nm_req_op = MEM_H;
    nm_exp_q.push_back({1'b1, 32'h0}); nm_exp_cyc_q.push_back(cyc + 1);
    @(negedge clk);
    nm_req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    nm_req_valid = 1'b1; nm_req_addr = 32'h1000; nm_req_op = MEM_D;
    nm_exp_q.push_back({1'b1, 32'h0}); nm_exp_cyc_q.push_back(cyc + 1);
    @(negedge clk);
    nm_req_valid = 1'b0;
    repeat (3) @(negedge clk);

    // Asynchronous reset while waiting for the second beat.
    rv_delay = 6;
    bus_push(64'h1000, 64'h1111_1111_1111_1111); bus_push(64'h1008, 64'h2222_2222_2222_2222);
    do_load(64'h1006, MEM_UW, 64'h0, 1'b0, -1, 1'b0);
    n = 0;
    while (dbg_state != S_WAIT1 && n < 50) begin @(negedge clk); n++; end
    if (dbg_state != S_WAIT1) fail("wait1_timeout");
    rstn = 1'b0;
    #1;
    check("arst_state", dbg_state, S_IDLE);
    check("arst_req_ready", req_ready, 1);
    check("arst_mem_req_valid", mem_req_valid, 0);
    check("arst_mem_req_addr", mem_req_addr, 0);
    check("arst_rsp_valid", rsp_valid, 0);
    check("arst_rsp_data", rsp_data, 0);
    check("arst_rsp_fault", rsp_fault, 0);
    exp_addr_q.delete();
    beat_q.delete();
    rv_delay = 1;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    bus_push(64'h2000, 64'hFEDC_BA98_7654_3210);
    do_load(64'h2000, MEM_D, 64'hFEDC_BA98_7654_3210, 1'b0, 3, 1'b1); wait_done();

    repeat (3) @(negedge clk);
    check("nm_no_bus_req", nm_req_seen, 0);
    check("nm_all_rsp_seen", nm_exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
